// File: rtl/exu_div_seq_pkg.sv
// Shared EXU types for the divide sequencer.
// Decode packet and divider state encoding.
package swerv_types;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  typedef struct packed {
    logic valid;
    logic unsign;
    logic rem;
  } div_pkt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/exu_div_seq_if.sv
// Decode/writeback side bundle of the divider.
// master = decode + writeback, slave = divider.
interface exu_div_seq_if #(
  parameter int WIDTH = 32
) ();
  import swerv_types::*;

  div_pkt_t           dp;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               flush;
  logic               busy;
  logic               finish;
  logic [WIDTH-1:0]   out;

  modport master (
    output dp, dividend, divisor, flush,
    input  busy, finish, out
  );

  modport slave (
    input  dp, dividend, divisor, flush,
    output busy, finish, out
  );

endinterface

// File: rtl/exu_div_seq_step.sv
// One radix-2 restoring division iteration.
// Pure combinational; used both in ITER and in FIX.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH:0] part;
  logic [WIDTH:0] trial;

  // rem stays below divisor_mag, so the top
  // bit of trial is the borrow/sign bit
  always_comb begin
    part  = {rem, q[WIDTH-1]};
    trial = part - {1'b0, divisor_mag};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = part[WIDTH-1:0];
      q_nxt   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/exu_div_seq.sv
// Iterative M-extension divide/remainder unit.
// Restoring radix-2 with short-circuited special cases.
module exu_div_seq
  import swerv_types::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  exu_div_seq_if.slave    dif
);

  localparam logic [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER =
    CNT_W'(WIDTH-2);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             rsel_q, rsel_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div0, ovf, special;
  logic             can_acc, accept;
  logic [WIDTH-1:0] spec_res;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] q_fin, r_fin, fix_res;

  always_comb begin
    sign_a  = !dif.dp.unsign && dif.dividend[WIDTH-1];
    sign_b  = !dif.dp.unsign && dif.divisor[WIDTH-1];
    mag_a   = sign_a ? -dif.dividend : dif.dividend;
    mag_b   = sign_b ? -dif.divisor : dif.divisor;
    div0    = dif.divisor == '0;
    ovf     = !dif.dp.unsign && dif.dividend == SMIN &&
              dif.divisor == '1;
    special = div0 || ovf;
    can_acc = state_q == IDLE || state_q == DONE;
    accept  = can_acc && dif.dp.valid && !dif.flush;
    if (div0)
      spec_res = dif.dp.rem ? dif.dividend : '1;
    else
      spec_res = dif.dp.rem ? '0 : SMIN;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_q),
    .q           (quo_q),
    .divisor_mag (dvs_q),
    .rem_nxt     (step_rem),
    .q_nxt       (step_quo)
  );

  // FIX performs the final iteration so finish lands 33 cycles after issue
  always_comb begin
    q_fin   = qneg_q ? -step_quo : step_quo;
    r_fin   = rneg_q ? -step_rem : step_rem;
    fix_res = rsel_q ? r_fin : q_fin;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : ITER;
      ITER: if (count_q == LAST_ITER) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        if (accept) state_d = special ? DONE : ITER;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (dif.flush) state_d = IDLE;
  end

  always_comb begin
    dif.busy   = state_q == ITER || state_q == FIX;
    dif.finish = state_q == DONE;
    dif.out    = out_q;
  end

  always_comb begin
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    out_d   = out_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    rsel_d  = rsel_q;
    if (accept && special) begin
      out_d = spec_res;
    end else if (accept) begin
      count_d = '0;
      rem_d   = '0;
      quo_d   = mag_a;
      dvs_d   = mag_b;
      qneg_d  = sign_a ^ sign_b;
      rneg_d  = sign_a;
      rsel_d  = dif.dp.rem;
    end else if (!dif.flush && state_q == ITER) begin
      rem_d   = step_rem;
      quo_d   = step_quo;
      count_d = count_q + 1'b1;
    end else if (!dif.flush && state_q == FIX) begin
      out_d = fix_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      out_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      out_q   <= out_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      rsel_q  <= rsel_d;
    end
  end

endmodule
